// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: round-robin scan controller for a 4-to-1 mux.
// It drives the mux select through channels 0..3 and samples the mux output once
// per channel. It then packs the four samples into a 4-bit snapshot and offers it
// downstream.
//
// Handshake (o_valid / i_ready): a snapshot transfers on a rising edge where both
// o_valid and i_ready are high. o_valid never drops and o_snapshot never changes
// until that edge. i_ready is ignored while o_valid is low.
//
// o_state is a debug view of the FSM. Its encoding is 0 IDLE, 1 SETTLE, 2 SAMPLE
// and 3 HOLD.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_mux_y,
  output logic [1:0] o_sel,
  output logic [3:0] o_snapshot,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The counter never has to hold more than SETTLE_CYCLES-1. It stays at least 1 bit wide.
  localparam int CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int LOAD_INT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_INT);

  // With no settle time, every channel goes straight to its sample cycle.
  localparam state_t SCAN_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       shadow;
  logic             cnt_done;

  assign cnt_done = (cnt == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one scan per start, then hold until the snapshot is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = SCAN_ENTRY;
      SETTLE:  if (cnt_done) state_next = SAMPLE;
      SAMPLE:  state_next = (o_sel == 2'd3) ? HOLD : SCAN_ENTRY;
      HOLD: begin
        if (i_ready) state_next = CONTINUOUS ? SCAN_ENTRY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: settle counter, channel select, partial samples and the published snapshot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      o_sel      <= 2'd0;
      shadow     <= 3'd0;
      o_snapshot <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_sel <= 2'd0;
            cnt   <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (!cnt_done) cnt <= cnt - CNT_W'(1);
        end
        SAMPLE: begin
          case (o_sel)
            2'd0:    shadow[0] <= i_mux_y;
            2'd1:    shadow[1] <= i_mux_y;
            2'd2:    shadow[2] <= i_mux_y;
            default: o_snapshot <= {i_mux_y, shadow};
          endcase
          if (o_sel == 2'd3) begin
            o_sel <= 2'd0;
          end else begin
            o_sel <= o_sel + 2'd1;
            cnt   <= CNT_LOAD;
          end
        end
        HOLD: begin
          // A back-to-back rescan starts on the handshake edge, so the counter reloads here.
          if (i_ready && CONTINUOUS) cnt <= CNT_LOAD;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs decoded from state: the snapshot is valid exactly while holding.
  always_comb begin
    o_valid = (state == HOLD);
    o_busy  = (state != IDLE);
    o_state = state;
  end

endmodule
